// File: rtl/char_rom_arbiter_pkg.sv
// Shared constants and types for the character-ROM arbiter.
package char_rom_arbiter_pkg;

  localparam int CHAR_W      = 8;
  localparam int YX_W        = 8;
  localparam int ROM_LAT_DEF = 1;

  // Requester slots used by the overlay renderers.
  localparam int REQ_GAMEOVER = 0;
  localparam int REQ_SCORE    = 1;
  localparam int REQ_MENU     = 2;

  // Requester index width; sized for the largest supported requester count (8).
  localparam int IDX_W = 3;

  // One entry of the tag pipeline: marks whether a ROM read was issued and for whom.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] id;
  } tag_t;

  // Round-robin pointer advance: index after idx, wrapping at n-1.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input int unsigned      n);
    if (idx == IDX_W'(n - 1)) return '0;
    else                      return idx + 1'b1;
  endfunction

endpackage

// File: rtl/char_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick
  import char_rom_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win_idx,
  output logic [N_REQ-1:0] win_oh
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  // Walk offsets 0..N_REQ-1 from ptr; the first eligible candidate wins.
  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!any && (cand == CW'(i)) && eligible[i]) begin
          any       = 1'b1;
          win_idx   = IDX_W'(i);
          win_oh[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/char_rom_arbiter.sv
// Shares one registered character ROM between several text-overlay requesters.
// Requests are granted round-robin, one per cycle; a tag pipeline follows each
// read through the ROM so the returned code is strobed back to its owner.
//
// Handshake: req[i] is a level request, held (with req_yx[i] stable) until gnt[i]
// is seen. gnt[i] is a one-cycle registered pulse marking that the address was
// issued; the requester drops req or presents its next address in that cycle.
// A request still high while its gnt is visible is masked, so it is never granted
// twice for the same pulse. rd_valid[i] is a one-cycle pulse with rd_code valid
// for that cycle only; there is no back-pressure on the return path.
module char_rom_arbiter
  import char_rom_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [YX_W*N_REQ-1:0] req_yx,
  output logic [N_REQ-1:0]      gnt,
  output logic [YX_W-1:0]       rom_char_yx,
  input  logic [CHAR_W-1:0]     rom_char_code,
  output logic [N_REQ-1:0]      rd_valid,
  output logic [CHAR_W-1:0]     rd_code
);

  logic [N_REQ-1:0]  gnt_q,      gnt_d;
  logic [YX_W-1:0]   yx_q,       yx_d;
  logic [IDX_W-1:0]  ptr_q,      ptr_d;
  logic [N_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [CHAR_W-1:0] rd_code_q,  rd_code_d;
  tag_t              tag_q [ROM_LAT+1];
  tag_t              tag_d [ROM_LAT+1];

  logic [N_REQ-1:0]  eligible;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic [YX_W-1:0]   pick_yx;
  tag_t              tag_out;

  // A requester whose grant is currently visible is masked from this round.
  assign eligible = req & ~gnt_q;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any      (pick_any),
    .win_idx  (pick_idx),
    .win_oh   (pick_oh)
  );

  // Issue side: grant pulse, ROM address mux and pointer advance.
  always_comb begin
    pick_yx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_yx = req_yx[YX_W*i +: YX_W];
    end
    gnt_d = pick_any ? pick_oh : '0;
    yx_d  = pick_any ? pick_yx : yx_q;
    ptr_d = pick_any ? wrap_inc(pick_idx, N_REQ) : ptr_q;
  end

  // Tag pipeline: stage 0 is aligned with the issued address, stage ROM_LAT with the ROM data.
  always_comb begin
    tag_d[0].valid = pick_any;
    tag_d[0].id    = pick_idx;
    for (int s = 1; s <= ROM_LAT; s++) tag_d[s] = tag_q[s-1];
  end

  // Return side: strobe the owner of the emerging tag and capture the ROM data.
  always_comb begin
    tag_out    = tag_q[ROM_LAT];
    rd_valid_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_out.valid && (tag_out.id == IDX_W'(i))) rd_valid_d[i] = 1'b1;
    end
    rd_code_d = tag_out.valid ? rom_char_code : '0;
  end

  // State registers; reset drops every in-flight tag so no stale read is strobed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      yx_q       <= '0;
      ptr_q      <= '0;
      rd_valid_q <= '0;
      rd_code_q  <= '0;
      for (int s = 0; s <= ROM_LAT; s++) tag_q[s] <= '0;
    end else begin
      gnt_q      <= gnt_d;
      yx_q       <= yx_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_code_q  <= rd_code_d;
      for (int s = 0; s <= ROM_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign gnt         = gnt_q;
  assign rom_char_yx = yx_q;
  assign rd_valid    = rd_valid_q;
  assign rd_code     = rd_code_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed bench for char_rom_arbiter with a 1-cycle ROM model and a cycle-stamped scoreboard.
module tb_char_rom_arbiter;

  localparam int N  = 3;
  localparam int W  = 16 + N + 8;  // {expected cycle, one-hot owner, data}
  localparam int RL = 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [8*N-1:0] req_yx;
  logic [N-1:0]   gnt;
  logic [7:0]     rom_char_yx;
  logic [7:0]     rom_char_code;
  logic [N-1:0]   rd_valid;
  logic [7:0]     rd_code;

  char_rom_arbiter #(.N_REQ(N), .ROM_LAT(RL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_yx        (req_yx),
    .gnt           (gnt),
    .rom_char_yx   (rom_char_yx),
    .rom_char_code (rom_char_code),
    .rd_valid      (rd_valid),
    .rd_code       (rd_code)
  );

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h47;
      8'h01:   return 8'h41;
      8'h05:   return 8'h4F;
      8'h08:   return 8'h52;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) rom_char_code <= rom_fn(rom_char_yx);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_gnt_q[$];
  logic [W-1:0] exp_rd_q[$];
  logic         mon_en = 1'b0;
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_yx(input int i, input logic [7:0] yx);
    req_yx[8*i +: 8] = yx;
  endtask

  task automatic exp_gnt_only(input int id, input logic [7:0] yx, input int gc);
    logic [N-1:0] oh;
    logic [15:0]  c;
    oh = '0;
    oh[id] = 1'b1;
    c = 16'(gc);
    exp_gnt_q.push_back({c, oh, yx});
  endtask

  task automatic issue_exp(input int id, input logic [7:0] yx, input int gc);
    logic [N-1:0] oh;
    logic [15:0]  c;
    oh = '0;
    oh[id] = 1'b1;
    c = 16'(gc + RL + 1);
    exp_gnt_only(id, yx, gc);
    exp_rd_q.push_back({c, oh, rom_fn(yx)});
  endtask

  // Monitor: each cycle either matches the queued entry due now or requires an idle output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_gnt_q.size() > 0 && exp_gnt_q[0][W-1:W-16] == cyc[15:0]) begin
        mon_e = exp_gnt_q.pop_front();
        check("gnt_addr", 32'({gnt, rom_char_yx}), 32'(mon_e[N+7:0]));
      end else begin
        check("gnt_idle", 32'(gnt), 32'd0);
      end
      if (exp_rd_q.size() > 0 && exp_rd_q[0][W-1:W-16] == cyc[15:0]) begin
        mon_e = exp_rd_q.pop_front();
        check("rd_data", 32'({rd_valid, rd_code}), 32'(mon_e[N+7:0]));
      end else begin
        check("rd_idle", 32'({rd_valid, rd_code}), 32'd0);
      end
    end
  end

  function automatic logic [7:0] a0(input int n);
    return (n % 2 == 1) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] a2(input int n);
    return (n % 2 == 1) ? 8'h05 : 8'h08;
  endfunction

  // ---------------- stimulus ----------------
  int k;
  int n0;
  int n2;

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    req_yx = '0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_gnt",  32'(gnt), 32'd0);
    check("rst_yx",   32'(rom_char_yx), 32'd0);
    check("rst_rdv",  32'(rd_valid), 32'd0);
    check("rst_code", 32'(rd_code), 32'd0);
    mon_en = 1'b1;
    repeat (2) step();

    // Single read from requester 0.
    k = cyc;
    req[0] = 1'b1;
    set_yx(0, 8'h00);
    issue_exp(0, 8'h00, k + 1);
    step();
    req[0] = 1'b0;
    repeat (4) step();

    // Simultaneous requests from reset: served 0, 1, 2.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    k = cyc;
    req = 3'b111;
    set_yx(0, 8'h01);
    set_yx(1, 8'h05);
    set_yx(2, 8'h08);
    issue_exp(0, 8'h01, k + 1);
    issue_exp(1, 8'h05, k + 2);
    issue_exp(2, 8'h08, k + 3);
    step(); req[0] = 1'b0;
    step(); req[1] = 1'b0;
    step(); req[2] = 1'b0;
    repeat (4) step();

    // Held request: masked while gnt is visible, re-granted two cycles later.
    k = cyc;
    req[1] = 1'b1;
    set_yx(1, 8'h05);
    issue_exp(1, 8'h05, k + 1);
    issue_exp(1, 8'h05, k + 3);
    repeat (3) step();
    req[1] = 1'b0;
    repeat (4) step();

    // Fairness: ptr is 2 here, so 2 wins first and the two then alternate every cycle.
    k = cyc;
    n0 = 0;
    n2 = 0;
    set_yx(0, a0(0));
    set_yx(2, a2(0));
    req = 3'b101;
    for (int j = 1; j <= 20; j++) begin
      if (j % 2 == 1) begin
        issue_exp(2, a2(n2), k + j);
        n2++;
      end else begin
        issue_exp(0, a0(n0), k + j);
        n0++;
      end
      step();
      if (j % 2 == 1) set_yx(2, a2(n2));
      else            set_yx(0, a0(n0));
    end
    req = '0;
    repeat (4) step();

    // Reset mid-operation: two grants issue, their reads are dropped.
    k = cyc;
    req = 3'b011;
    set_yx(0, 8'h00);
    set_yx(1, 8'h01);
    exp_gnt_only(1, 8'h01, k + 1);
    exp_gnt_only(0, 8'h00, k + 2);
    step(); req[1] = 1'b0;
    step(); req[0] = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_gnt",  32'(gnt), 32'd0);
    check("mid_rst_yx",   32'(rom_char_yx), 32'd0);
    check("mid_rst_rdv",  32'(rd_valid), 32'd0);
    check("mid_rst_code", 32'(rd_code), 32'd0);
    // ptr is back to 0: requester 0 wins before 2.
    req = 3'b101;
    set_yx(0, 8'h08);
    set_yx(2, 8'h05);
    issue_exp(0, 8'h08, k + 4);
    issue_exp(2, 8'h05, k + 5);
    step(); req[0] = 1'b0;
    step(); req[2] = 1'b0;
    repeat (4) step();

    // Idle bus: address holds the last issued value.
    for (int j = 0; j < 10; j++) begin
      step();
      check("idle_yx_hold", 32'(rom_char_yx), 32'h05);
    end

    check("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
    check("rd_queue_empty",  32'(exp_rd_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
